// File: rtl/pgm_rd.sv
// pgm_rd: egress buffer between pgm and GOE.
// Three FIFOs hold packet words, PHVs and per-packet verdicts from pgm.
// A read FSM forwards whole packets whose verdict is 1 and silently drops
// the rest. Optional statistics are built when PGM_RD_STAT_EN is defined.
//
// Handshake: every *_wr strobe is a single-cycle write with no ready
// return; flow control in each direction uses registered almost-full
// levels (out_rd_alf/out_rd_phv_alf towards pgm, in_rd_alf/in_rd_phv_alf
// from GOE). GOE levels are sampled only when a packet is about to start.
module pgm_rd #(
  parameter int DATA_AW    = 8,
  parameter int PHV_AW     = 2,
  parameter int ALF_MARGIN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1023:0] in_rd_phv,
  input  logic          in_rd_phv_wr,
  output logic          out_rd_phv_alf,
  input  logic [133:0]  in_rd_data,
  input  logic          in_rd_data_wr,
  input  logic          in_rd_valid,
  input  logic          in_rd_valid_wr,
  output logic          out_rd_alf,
  input  logic          in_rd_sent_start_flag,
  input  logic          in_rd_sent_finish_flag,
  output logic [1023:0] out_rd_phv,
  output logic          out_rd_phv_wr,
  input  logic          in_rd_phv_alf,
  output logic [133:0]  out_rd_data,
  output logic          out_rd_data_wr,
  output logic          out_rd_valid,
  output logic          out_rd_valid_wr,
  input  logic          in_rd_alf,
  output logic          out_rd_ovf,
  output logic [31:0]   out_rd_pkt_cnt,
  output logic [31:0]   out_rd_drop_cnt,
  output logic [31:0]   out_rd_run_cnt
);

  localparam int DATA_DEPTH = 1 << DATA_AW;
  localparam int PHV_DEPTH  = 1 << PHV_AW;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DISCARD = 2'd2} state_t;
  state_t state;

  logic [133:0]         data_mem [DATA_DEPTH];
  logic [DATA_AW-1:0]   data_wp, data_rp;
  logic [DATA_AW:0]     data_used;
  logic                 data_push, data_pop, data_full, data_empty;

  logic [1023:0]        phv_mem [PHV_DEPTH];
  logic [PHV_AW-1:0]    phv_wp, phv_rp;
  logic [PHV_AW:0]      phv_used;
  logic                 phv_push, phv_full, phv_empty;

  logic [PHV_DEPTH-1:0] vrd_mem;
  logic [PHV_AW-1:0]    vrd_wp, vrd_rp;
  logic [PHV_AW:0]      vrd_used;
  logic                 vrd_push, vrd_full, vrd_empty;

  logic [133:0]         cur_word;
  logic                 cur_tail;
  logic                 start_send, start_drop, fwd, pkt_done;

  // Occupancy never exceeds depth, so the MSB of the count marks full.
  assign data_full  = data_used[DATA_AW];
  assign data_empty = (data_used == '0);
  assign phv_full   = phv_used[PHV_AW];
  assign phv_empty  = (phv_used == '0);
  assign vrd_full   = vrd_used[PHV_AW];
  assign vrd_empty  = (vrd_used == '0);

  assign data_push  = in_rd_data_wr  && !data_full;
  assign phv_push   = in_rd_phv_wr   && !phv_full;
  assign vrd_push   = in_rd_valid_wr && !vrd_full;

  assign cur_word   = data_mem[data_rp];
  assign cur_tail   = (cur_word[133:132] == 2'b10);

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (data_push) data_mem[data_wp] <= in_rd_data;
    if (phv_push)  phv_mem[phv_wp]   <= in_rd_phv;
    if (vrd_push)  vrd_mem[vrd_wp]   <= in_rd_valid;
  end

  // FIFO pointers, occupancy, sticky overflow and almost-full levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_wp        <= '0;
      data_rp        <= '0;
      data_used      <= '0;
      phv_wp         <= '0;
      phv_rp         <= '0;
      phv_used       <= '0;
      vrd_wp         <= '0;
      vrd_rp         <= '0;
      vrd_used       <= '0;
      out_rd_ovf     <= 1'b0;
      out_rd_alf     <= 1'b0;
      out_rd_phv_alf <= 1'b0;
    end else begin
      if (data_push) data_wp <= data_wp + 1'b1;
      if (data_pop)  data_rp <= data_rp + 1'b1;
      case ({data_push, data_pop})
        2'b10:   data_used <= data_used + 1'b1;
        2'b01:   data_used <= data_used - 1'b1;
        default: ;
      endcase
      if (phv_push) phv_wp <= phv_wp + 1'b1;
      if (pkt_done) phv_rp <= phv_rp + 1'b1;
      case ({phv_push, pkt_done})
        2'b10:   phv_used <= phv_used + 1'b1;
        2'b01:   phv_used <= phv_used - 1'b1;
        default: ;
      endcase
      if (vrd_push) vrd_wp <= vrd_wp + 1'b1;
      if (pkt_done) vrd_rp <= vrd_rp + 1'b1;
      case ({vrd_push, pkt_done})
        2'b10:   vrd_used <= vrd_used + 1'b1;
        2'b01:   vrd_used <= vrd_used - 1'b1;
        default: ;
      endcase
      out_rd_ovf     <= out_rd_ovf | (in_rd_data_wr & data_full)
                                   | (in_rd_phv_wr & phv_full)
                                   | (in_rd_valid_wr & vrd_full);
      out_rd_alf     <= int'(data_used) >= DATA_DEPTH - ALF_MARGIN;
      out_rd_phv_alf <= int'(phv_used) >= PHV_DEPTH - 1;
    end
  end

  // Packet start decision and word pop; a verdict implies the whole packet
  // is already buffered, so the head word is popped on the same cycle.
  always_comb begin
    start_send = 1'b0;
    start_drop = 1'b0;
    data_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!vrd_empty && !phv_empty && !data_empty) begin
          if (vrd_mem[vrd_rp]) start_send = !in_rd_alf && !in_rd_phv_alf;
          else                 start_drop = 1'b1;
          data_pop = start_send | start_drop;
        end
      end
      SEND, DISCARD: data_pop = !data_empty;
      default: ;
    endcase
  end

  assign fwd      = start_send || (state == SEND);
  assign pkt_done = data_pop && cur_tail;

  // Read FSM with registered GOE outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      out_rd_data     <= '0;
      out_rd_data_wr  <= 1'b0;
      out_rd_phv      <= '0;
      out_rd_phv_wr   <= 1'b0;
      out_rd_valid    <= 1'b0;
      out_rd_valid_wr <= 1'b0;
    end else begin
      out_rd_data_wr  <= data_pop && fwd;
      out_rd_data     <= (data_pop && fwd) ? cur_word : '0;
      out_rd_phv_wr   <= start_send;
      if (start_send) out_rd_phv <= phv_mem[phv_rp];
      out_rd_valid_wr <= pkt_done && fwd;
      out_rd_valid    <= pkt_done && fwd;
      if (pkt_done)        state <= IDLE;
      else if (start_send) state <= SEND;
      else if (start_drop) state <= DISCARD;
    end
  end

`ifdef PGM_RD_STAT_EN
  logic run_open;
  logic tail_fwd, tail_drop;

  assign tail_fwd  = pkt_done && fwd;
  assign tail_drop = pkt_done && !fwd;

  // Packet statistics and the start/finish run window; start beats finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_open        <= 1'b0;
      out_rd_pkt_cnt  <= '0;
      out_rd_drop_cnt <= '0;
      out_rd_run_cnt  <= '0;
    end else begin
      if (tail_fwd)  out_rd_pkt_cnt  <= out_rd_pkt_cnt + 32'd1;
      if (tail_drop) out_rd_drop_cnt <= out_rd_drop_cnt + 32'd1;
      if (in_rd_sent_start_flag) begin
        run_open       <= 1'b1;
        out_rd_run_cnt <= '0;
      end else begin
        if (in_rd_sent_finish_flag) run_open <= 1'b0;
        if (tail_fwd && run_open) out_rd_run_cnt <= out_rd_run_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_flags;
  assign unused_flags    = in_rd_sent_start_flag ^ in_rd_sent_finish_flag;
  assign out_rd_pkt_cnt  = '0;
  assign out_rd_drop_cnt = '0;
  assign out_rd_run_cnt  = '0;
`endif

endmodule

// File: tb/tb_pgm_rd.sv
// tb_pgm_rd: scoreboard bench for pgm_rd. Directed scenarios plus a
// randomized phase; expected words come from the packets the driver issues.
module tb_pgm_rd;

  logic          clk = 1'b0;
  logic          rst;
  logic [1023:0] in_rd_phv;
  logic          in_rd_phv_wr;
  logic          out_rd_phv_alf;
  logic [133:0]  in_rd_data;
  logic          in_rd_data_wr;
  logic          in_rd_valid;
  logic          in_rd_valid_wr;
  logic          out_rd_alf;
  logic          in_rd_sent_start_flag;
  logic          in_rd_sent_finish_flag;
  logic [1023:0] out_rd_phv;
  logic          out_rd_phv_wr;
  logic          in_rd_phv_alf;
  logic [133:0]  out_rd_data;
  logic          out_rd_data_wr;
  logic          out_rd_valid;
  logic          out_rd_valid_wr;
  logic          in_rd_alf;
  logic          out_rd_ovf;
  logic [31:0]   out_rd_pkt_cnt;
  logic [31:0]   out_rd_drop_cnt;
  logic [31:0]   out_rd_run_cnt;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pgm_rd dut (
    .clk(clk), .rst(rst),
    .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr), .out_rd_phv_alf(out_rd_phv_alf),
    .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
    .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr), .out_rd_alf(out_rd_alf),
    .in_rd_sent_start_flag(in_rd_sent_start_flag), .in_rd_sent_finish_flag(in_rd_sent_finish_flag),
    .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr), .in_rd_phv_alf(in_rd_phv_alf),
    .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
    .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr), .in_rd_alf(in_rd_alf),
    .out_rd_ovf(out_rd_ovf), .out_rd_pkt_cnt(out_rd_pkt_cnt),
    .out_rd_drop_cnt(out_rd_drop_cnt), .out_rd_run_cnt(out_rd_run_cnt)
  );

  // ---------------- scoreboard state ----------------
  localparam int W = 136;        // {is_head, is_tail, word[133:0]}
  logic [W-1:0]  exp_q[$];
  logic [1023:0] exp_phv_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int out_word_cnt = 0;
  int last_head_cyc = -1;
  int tail_cyc = 0;
  bit in_pkt = 1'b0;
  bit rand_bp = 1'b0;

  // Reference model: packet-level counts and run window.
  int exp_pkt = 0;
  int exp_drop = 0;
  int exp_run = 0;
  bit win = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_phv(input logic [1023:0] act, input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL head_phv: got low bits %0h expected low bits %0h (cycle %0d)",
               act[127:0], exp[127:0], cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event seen at cycle %0d, none expected", name, cyc);
  endtask

  function automatic logic [31:0] stat(input int v);
`ifdef PGM_RD_STAT_EN
    return 32'(v);
`else
    return (v == v) ? 32'd0 : 32'd1;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      in_pkt = 1'b0;
    end else if (out_rd_data_wr) begin
      out_word_cnt++;
      if (exp_q.size() == 0) begin
        fail_now("unexpected_word");
      end else begin
        e = exp_q.pop_front();
        check("out_word", W'(out_rd_data), W'(e[133:0]));
        check("phv_wr_on_head", W'(out_rd_phv_wr), W'(e[135]));
        check("valid_wr_on_tail", W'(out_rd_valid_wr), W'(e[134]));
        if (e[135]) begin
          last_head_cyc = cyc;
          if (exp_phv_q.size() == 0) fail_now("unexpected_phv");
          else check_phv(out_rd_phv, exp_phv_q.pop_front());
        end
        if (e[134]) check("valid_on_tail", W'(out_rd_valid), W'(1));
        in_pkt = !e[134];
      end
    end else begin
      if (in_pkt) fail_now("mid_pkt_gap");
      check("stray_strobe", W'({out_rd_phv_wr, out_rd_valid_wr}), W'(0));
    end
  end

  // ---------------- random GOE backpressure ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) begin
        in_rd_alf     = ($urandom_range(0, 3) == 0);
        in_rd_phv_alf = ($urandom_range(0, 5) == 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input int len, input bit vld, input bit vdly,
                          input logic [1023:0] phv, input bit seq);
    logic [5:0]   hdr;
    logic [127:0] pay;
    if (vld) begin
      exp_phv_q.push_back(phv);
      exp_pkt++;
      if (win) exp_run++;
    end else begin
      exp_drop++;
    end
    for (int i = 0; i < len; i++) begin
      hdr = (i == 0) ? 6'b010000 : (i == len - 1) ? 6'b100000 : 6'b110000;
      pay = seq ? 128'(i + 1) : {$urandom(), $urandom(), $urandom(), $urandom()};
      if (vld) exp_q.push_back({(i == 0), (i == len - 1), hdr, pay});
      tick();
      in_rd_data_wr  = 1'b1;
      in_rd_data     = {hdr, pay};
      in_rd_phv_wr   = (i == 0);
      in_rd_phv      = phv;
      in_rd_valid_wr = (i == len - 1) && !vdly;
      in_rd_valid    = vld;
      if (i == len - 1) tail_cyc = cyc;
    end
    tick();
    in_rd_data_wr  = 1'b0;
    in_rd_phv_wr   = 1'b0;
    in_rd_valid_wr = vdly;
    in_rd_valid    = vld;
    if (vdly) begin
      tick();
      in_rd_valid_wr = 1'b0;
    end
  endtask

  function automatic logic [1023:0] rand_phv();
    logic [1023:0] p;
    for (int k = 0; k < 32; k++) p[k*32 +: 32] = $urandom();
    return p;
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", W'(exp_q.size() == 0), W'(1));
    repeat (3) tick();
  endtask

  task automatic wait_room();
    int n = 0;
    while ((out_rd_alf || out_rd_phv_alf) && n < 200) begin
      tick();
      n++;
    end
    check("room_timeout", W'(n < 200), W'(1));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_pkt_cnt"},  W'(out_rd_pkt_cnt),  W'(stat(exp_pkt)));
    check({tag, "_drop_cnt"}, W'(out_rd_drop_cnt), W'(stat(exp_drop)));
    check({tag, "_run_cnt"},  W'(out_rd_run_cnt),  W'(stat(exp_run)));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data_wr"},  W'(out_rd_data_wr), W'(0));
    check({tag, "_phv_wr"},   W'(out_rd_phv_wr), W'(0));
    check({tag, "_valid_wr"}, W'(out_rd_valid_wr), W'(0));
    check({tag, "_valid"},    W'(out_rd_valid), W'(0));
    check({tag, "_data"},     W'(out_rd_data), W'(0));
    check({tag, "_phv"},      W'(out_rd_phv == '0), W'(1));
    check({tag, "_ovf"},      W'(out_rd_ovf), W'(0));
    check({tag, "_alf"},      W'({out_rd_alf, out_rd_phv_alf}), W'(0));
    check({tag, "_pkt_cnt"},  W'(out_rd_pkt_cnt), W'(0));
    check({tag, "_drop_cnt"}, W'(out_rd_drop_cnt), W'(0));
    check({tag, "_run_cnt"},  W'(out_rd_run_cnt), W'(0));
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_phv_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    exp_run = 0;
    win = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_flags(input bit s, input bit f);
    tick();
    in_rd_sent_start_flag  = s;
    in_rd_sent_finish_flag = f;
    tick();
    in_rd_sent_start_flag  = 1'b0;
    in_rd_sent_finish_flag = 1'b0;
    if (s) begin
      win = 1'b1;
      exp_run = 0;
    end else if (f) begin
      win = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n0;
    int t;
    logic [5:0]   hdr;
    logic [133:0] w;
    logic [1023:0] p;

    rst = 1'b1;
    in_rd_phv = '0; in_rd_phv_wr = 1'b0;
    in_rd_data = '0; in_rd_data_wr = 1'b0;
    in_rd_valid = 1'b0; in_rd_valid_wr = 1'b0;
    in_rd_sent_start_flag = 1'b0; in_rd_sent_finish_flag = 1'b0;
    in_rd_phv_alf = 1'b0; in_rd_alf = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Basic forward with fixed payload and PHV; head two cycles after tail.
    send_pkt(4, 1'b1, 1'b0, 1024'h5A, 1'b1);
    wait_drain(50);
    check("fwd_latency", W'(last_head_cyc - tail_cyc), W'(2));
    check_counts("basic");

    // Discard then a valid packet.
    n0 = out_word_cnt;
    send_pkt(4, 1'b0, 1'b0, 1024'h5A, 1'b1);
    repeat (10) tick();
    check("discard_silent", W'(out_word_cnt - n0), W'(0));
    send_pkt(5, 1'b1, 1'b1, rand_phv(), 1'b0);
    wait_drain(50);
    check_counts("discard");

    // GOE backpressure held at start, then re-asserted mid-packet.
    in_rd_alf = 1'b1;
    n0 = out_word_cnt;
    send_pkt(6, 1'b1, 1'b0, rand_phv(), 1'b0);
    repeat (10) tick();
    check("bp_hold", W'(out_word_cnt - n0), W'(0));
    in_rd_alf = 1'b0;
    t = cyc;
    tick();
    tick();
    in_rd_alf = 1'b1;
    wait_drain(50);
    check("bp_release_head", W'(last_head_cyc - t), W'(1));
    in_rd_alf = 1'b0;
    check_counts("bp");

    // Fill to almost-full, then overflow the data FIFO by one word.
    for (int i = 1; i <= 257; i++) begin
      tick();
      if (i == 241) check("alf_below_level", W'(out_rd_alf), W'(0));
      if (i == 242) check("alf_at_level", W'(out_rd_alf), W'(1));
      if (i == 257) check("ovf_before_extra", W'(out_rd_ovf), W'(0));
      hdr = (i == 1 || i == 257) ? 6'b010000 : (i == 256) ? 6'b100000 : 6'b110000;
      w = {hdr, 128'(i) + 128'h1000};
      if (i <= 256) exp_q.push_back({(i == 1), (i == 256), w});
      in_rd_data_wr = 1'b1;
      in_rd_data    = w;
    end
    tick();
    in_rd_data_wr = 1'b0;
    check("ovf_set", W'(out_rd_ovf), W'(1));
    p = rand_phv();
    exp_phv_q.push_back(p);
    exp_pkt++;
    if (win) exp_run++;
    in_rd_phv_wr = 1'b1; in_rd_phv = p;
    in_rd_valid_wr = 1'b1; in_rd_valid = 1'b1;
    tick();
    in_rd_phv_wr = 1'b0; in_rd_valid_wr = 1'b0;
    wait_drain(600);
    send_pkt(3, 1'b1, 1'b0, rand_phv(), 1'b0);
    wait_drain(50);
    check("ovf_sticky", W'(out_rd_ovf), W'(1));
    check_counts("fill");

    // Reset in the middle of a forwarded packet.
    n0 = out_word_cnt;
    send_pkt(6, 1'b1, 1'b0, rand_phv(), 1'b0);
    t = 0;
    while (out_word_cnt - n0 < 2 && t < 50) begin
      tick();
      t++;
    end
    check("mid_pkt_start_timeout", W'(t < 50), W'(1));
    rst = 1'b1;
    tick();
    check_zero("mid_rst");
    exp_q.delete();
    exp_phv_q.delete();
    exp_pkt = 0; exp_drop = 0; exp_run = 0; win = 1'b0;
    tick();
    rst = 1'b0;
    send_pkt(4, 1'b1, 1'b0, rand_phv(), 1'b0);
    wait_drain(50);
    check_counts("post_rst");

    // Run window: start, three forwarded, finish, one more forwarded.
    do_reset();
    pulse_flags(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) send_pkt($urandom_range(2, 6), 1'b1, 1'b0, rand_phv(), 1'b0);
    wait_drain(100);
    pulse_flags(1'b0, 1'b1);
    send_pkt(3, 1'b1, 1'b0, rand_phv(), 1'b0);
    wait_drain(50);
    check_counts("run_window");

    // Randomized traffic with GOE backpressure; start and finish together open the window.
    pulse_flags(1'b1, 1'b1);
    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      wait_room();
      send_pkt($urandom_range(2, 8), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
               rand_phv(), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_bp = 1'b0;
    tick();
    in_rd_alf = 1'b0;
    in_rd_phv_alf = 1'b0;
    wait_drain(2000);
    pulse_flags(1'b0, 1'b1);
    check_counts("random");
    check("random_no_ovf", W'(out_rd_ovf), W'(0));
    check("random_phv_q_empty", W'(exp_phv_q.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pgm_rd.md
# pgm_rd

Egress stage directly downstream of the packet generator module (pgm). Buffers the 134-bit packet words, per-packet valid verdicts and 1024-bit PHVs that pgm produces. Forwards whole packets to GOE, discarding any packet whose verdict is invalid. Drives the almost-full backpressure seen by pgm and keeps per-run packet statistics bounded by pgm's sent start/finish flags.

## Interface
Parameters:
- DATA_AW, 8, log2 depth of data word FIFO (256 words)
- PHV_AW, 2, log2 depth of PHV FIFO and verdict FIFO (4 entries)
- ALF_MARGIN, 16, free-word threshold for out_rd_alf

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- in_rd_phv  in  1024  PHV from pgm
- in_rd_phv_wr  in  1  PHV write strobe
- out_rd_phv_alf  out  1  PHV FIFO almost full, to pgm
- in_rd_data  in  134  packet word; [133:128] 010000 head, 110000 body, 100000 tail
- in_rd_data_wr  in  1  word write strobe
- in_rd_valid  in  1  packet verdict, 1 = forward
- in_rd_valid_wr  in  1  verdict strobe
- out_rd_alf  out  1  data FIFO almost full, to pgm
- in_rd_sent_start_flag  in  1  pgm run start pulse
- in_rd_sent_finish_flag  in  1  pgm run finish pulse
- out_rd_phv  out  1024  PHV to GOE
- out_rd_phv_wr  out  1  PHV strobe
- in_rd_phv_alf  in  1  GOE PHV almost full
- out_rd_data  out  134  word to GOE
- out_rd_data_wr  out  1  word strobe
- out_rd_valid  out  1  verdict to GOE
- out_rd_valid_wr  out  1  verdict strobe
- in_rd_alf  in  1  GOE data almost full
- out_rd_ovf  out  1  sticky overflow error
- out_rd_pkt_cnt  out  32  forwarded packets
- out_rd_drop_cnt  out  32  discarded packets
- out_rd_run_cnt  out  32  packets forwarded inside current start/finish window

## Operation
- Write side: each in_rd_data_wr pushes one word into the data FIFO. Each in_rd_phv_wr pushes into the PHV FIFO. Each in_rd_valid_wr pushes in_rd_valid into the verdict FIFO.
- A verdict arrives on the tail cycle or any later cycle before the next head. pgm guarantees one PHV and one verdict per packet.
- Push to a full FIFO: the item is dropped and out_rd_ovf is set. out_rd_ovf clears only on rst.
- Read FSM states: IDLE, SEND, DISCARD.
- IDLE → SEND: verdict FIFO non-empty, PHV FIFO non-empty, verdict = 1, in_rd_alf = 0, in_rd_phv_alf = 0.
- IDLE → DISCARD: verdict FIFO non-empty, PHV FIFO non-empty, verdict = 0. No backpressure check.
- SEND: pops one word per cycle and drives it with out_rd_data_wr. The head word carries out_rd_phv/out_rd_phv_wr. The tail word carries out_rd_valid = 1 and out_rd_valid_wr. Tail pops the verdict and PHV FIFOs, increments pkt_cnt, and returns to IDLE.
- DISCARD: pops words silently until the tail, then pops the PHV and verdict FIFOs, increments drop_cnt, and returns to IDLE.
- GOE backpressure is sampled only at packet start. A packet in SEND always completes.
- Run window: in_rd_sent_start_flag clears out_rd_run_cnt and opens the window. in_rd_sent_finish_flag closes it. run_cnt increments on a forwarded tail while the window is open. If start and finish arrive in the same cycle, start wins.
- Counters wrap at 2^32.
- Simultaneous push and pop on any FIFO: occupancy unchanged.

## Timing
- Reset: all outputs 0, FIFOs empty, FSM IDLE, window closed.
- Outputs are registered.
- Tail and verdict written in cycle N → verdict visible in N+1 → FSM leaves IDLE in N+1 → first output word in N+2.
- Packets are back-to-back with one IDLE cycle between tail and next head.
- out_rd_alf is registered: high the cycle after data FIFO used ≥ 2^DATA_AW − ALF_MARGIN.
- out_rd_phv_alf is registered: high the cycle after PHV FIFO used ≥ 2^PHV_AW − 1.
- rst mid-packet: outputs 0 in the next cycle. Partial packet state is discarded and no tail or verdict strobe is emitted.

## Configuration
- PGM_RD_STAT_EN defined: out_rd_pkt_cnt, out_rd_drop_cnt, out_rd_run_cnt and the window logic are built.
- PGM_RD_STAT_EN undefined: all three counters are tied to 0 and start/finish flags are ignored. Forwarding and discarding are unchanged.

## Test plan
- Basic forward: 4-word packet (headers 010000, 110000, 110000, 100000; payload 1..4), valid = 1 on tail, PHV = 1024'h5A. Expect 4 consecutive output words starting 2 cycles after the tail, phv_wr with the head, valid_wr/valid = 1 with the tail, pkt_cnt = 1.
- Discard: same packet with valid = 0. Expect no output strobes and drop_cnt = 1. A following valid packet is forwarded intact.
- GOE backpressure: in_rd_alf = 1 while a packet is queued. Expect no output. Deassert at cycle T → head at T+1. Re-asserting alf mid-packet does not stall it.
- Fill and overflow: write 250 words with no verdict. Expect out_rd_alf high once used ≥ 240. Push 7 more words → out_rd_ovf = 1 and the extra word is lost.
- Reset mid-packet: rst after 2 words are sent. Expect all outputs 0 next cycle and counters 0. The next packet forwards cleanly.
- Run window: start pulse, 3 valid packets, finish pulse, 1 valid packet. Expect run_cnt = 3 and pkt_cnt = 4.
